uart_tx_fifo_param: RTL

//  Parametrised UART transmitter; successor to the fixed 8-bit parity-select TX.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx_fifo_param.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the parametrised UART transmitter.
// Parity modes, FSM state codes, divider and FIFO count-width helpers.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;
    localparam logic [2:0] ST_MAB    = 3'd6;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter.
// Counts 0..DIV-1, ticks on DIV-1; clear restarts the bit period.
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign bit_tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with TX FIFO, runtime parity mode and 1/2 stop bits.
// Optional line-break generation when UART_TX_BREAK_EN is defined.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_BITS-1:0]            s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [1:0]                      parity_mode,
    input  logic                            two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                            brk,
`endif
    output logic                            tx,
    output logic                            busy,
    output logic [cnt_w(FIFO_DEPTH)-1:0]    fifo_count
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = cnt_w(FIFO_DEPTH);
    localparam int BW  = $clog2(DATA_BITS);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 run;
    logic                 push;
    logic                 pop;
    logic                 have;

    logic [2:0]           state;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_idx;
    logic                 par_en;
    logic                 par_bit;
    logic                 two_l;
    logic                 stop_idx;
    logic                 idle_go;
    logic                 stop_done;
    logic                 clear;
    logic                 bit_tick;

    assign s_ready    = run && (count != CW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign have       = (count != '0);
    assign fifo_count = count;
    assign stop_done  = (state == ST_STOP) && bit_tick
                      && (stop_idx || !two_l);
    assign pop        = idle_go || (stop_done && have);

`ifdef UART_TX_BREAK_EN
    localparam int BRK_LEN = (DATA_BITS + 3) * DIV;
    localparam int KW      = $clog2(BRK_LEN + 1);

    logic [KW-1:0] brk_cnt;
    logic          brk_done;

    assign brk_done = !brk && (brk_cnt == KW'(BRK_LEN - 1));
    assign idle_go  = (state == ST_IDLE) && have && !brk;
    assign clear    = idle_go || ((state == ST_BREAK) && brk_done);

    // Saturates so a long-held brk simply extends the break.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brk_cnt <= '0;
        end else if (state != ST_BREAK) begin
            brk_cnt <= '0;
        end else if (brk_cnt != KW'(BRK_LEN - 1)) begin
            brk_cnt <= brk_cnt + 1'b1;
        end
    end
`else
    assign idle_go = (state == ST_IDLE) && have;
    assign clear   = idle_go;
`endif

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            run    <= 1'b0;
        end else begin
            run <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The pop branch comes last so it overrides the STOP exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            two_l    <= 1'b0;
            stop_idx <= 1'b0;
        end else begin
            case (state)
`ifdef UART_TX_BREAK_EN
                ST_IDLE: begin
                    if (brk) begin
                        state <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (brk_done) begin
                        state <= ST_MAB;
                    end
                end
                ST_MAB: begin
                    if (bit_tick) begin
                        state <= ST_IDLE;
                    end
                end
`else
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
`endif
                ST_START: begin
                    if (bit_tick) begin
                        state    <= ST_DATA;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            state <= par_en ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (!stop_done) begin
                            stop_idx <= 1'b1;
                        end else if (!have) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (pop) begin
                state   <= ST_START;
                shreg   <= mem[rd_ptr];
                par_en  <= (parity_mode == PAR_EVEN)
                        || (parity_mode == PAR_ODD);
                par_bit <= (parity_mode == PAR_ODD) ^ (^mem[rd_ptr]);
                two_l   <= two_stop;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else begin
            busy <= (state != ST_IDLE);
            case (state)
                ST_START:  tx <= 1'b0;
                ST_DATA:   tx <= shreg[0];
                ST_PARITY: tx <= par_bit;
                ST_BREAK:  tx <= 1'b0;
                default:   tx <= 1'b1;
            endcase
        end
    end

endmodule
